// File: rtl/beam_power_window_trigger_if.sv
// Sample stream, threshold, window-power and trigger handshake bundle for
// beam_power_window_trigger. The slave modport is the trigger block itself.
interface beam_power_window_trigger_if #(
    parameter int unsigned NSAMP_LOG2 = 4
);
    localparam int unsigned ACC_W = 15 + NSAMP_LOG2;

    logic [7:0]       dat_i;
    logic             valid_i;
    logic [ACC_W-1:0] thresh_i;
    logic [ACC_W-1:0] pwr_o;
    logic             pwr_valid_o;
    logic             trig_valid_o;
    logic             trig_ready_i;
    logic [ACC_W-1:0] trig_pwr_o;
    logic [7:0]       drop_cnt_o;

    modport slave (
        input  dat_i, valid_i, thresh_i, trig_ready_i,
        output pwr_o, pwr_valid_o, trig_valid_o, trig_pwr_o, drop_cnt_o
    );

    modport master (
        output dat_i, valid_i, thresh_i, trig_ready_i,
        input  pwr_o, pwr_valid_o, trig_valid_o, trig_pwr_o, drop_cnt_o
    );
endinterface

// File: rtl/beam_power_window_trigger.sv
// Beam power over a 2^NSAMP_LOG2-sample window of offset-binary beamsums,
// with a threshold trigger, post-trigger holdoff and valid/ready hand-off.
module beam_power_window_trigger #(
    parameter int unsigned NSAMP_LOG2 = 4,
    parameter int unsigned HOLDOFF    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    beam_power_window_trigger_if.slave bus
);
    localparam int unsigned ACC_W = 15 + NSAMP_LOG2;
    localparam int unsigned HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic {IDLE, PEND} trig_state_e;

    // Squaring |dat_i - 128| gives the same result as squaring the signed value
    logic [7:0]  mag8;
    logic [14:0] mag;

    always_comb begin
        mag8 = bus.dat_i[7] ? (bus.dat_i - 8'd128) : (8'd128 - bus.dat_i);
        mag  = {7'b0, mag8};
    end

    logic [14:0] sq_q;
    logic        sq_vld_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sq_q     <= '0;
            sq_vld_q <= 1'b0;
        end else begin
            sq_vld_q <= bus.valid_i;
            if (bus.valid_i) begin
                sq_q <= mag * mag;
            end
        end
    end

    logic [NSAMP_LOG2-1:0] win_cnt_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_sum;
    logic [ACC_W-1:0]      pwr_q;
    logic                  pwr_vld_q;

    always_comb begin
        acc_sum = acc_q + ACC_W'(sq_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
            pwr_q     <= '0;
            pwr_vld_q <= 1'b0;
        end else begin
            pwr_vld_q <= 1'b0;
            if (sq_vld_q) begin
                win_cnt_q <= win_cnt_q + NSAMP_LOG2'(1);
                if (win_cnt_q == '1) begin
                    pwr_q     <= acc_sum;
                    pwr_vld_q <= 1'b1;
                    acc_q     <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    trig_state_e      state_q;
    logic             trig_vld_q;
    logic [ACC_W-1:0] trig_pwr_q;
    logic [HO_W-1:0]  hold_q;
    logic [7:0]       drop_q;

    logic crossing;
    logic armed;
    logic accept;
    logic fire;
    logic lost;

    // A crossing coinciding with acceptance of the old trigger replaces it
    always_comb begin
        crossing = pwr_vld_q && (pwr_q > bus.thresh_i);
        armed    = (hold_q == '0);
        accept   = trig_vld_q && bus.trig_ready_i;
        fire     = crossing && armed && (!trig_vld_q || accept);
        lost     = crossing && armed && trig_vld_q && !accept;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            trig_vld_q <= 1'b0;
            trig_pwr_q <= '0;
            hold_q     <= '0;
            drop_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_q    <= PEND;
                        trig_vld_q <= 1'b1;
                        trig_pwr_q <= pwr_q;
                    end
                end
                PEND: begin
                    if (fire) begin
                        trig_pwr_q <= pwr_q;
                    end else if (accept) begin
                        state_q    <= IDLE;
                        trig_vld_q <= 1'b0;
                    end
                end
            endcase

            if (fire) begin
                hold_q <= HO_W'(HOLDOFF);
            end else if (pwr_vld_q && !armed) begin
                hold_q <= hold_q - HO_W'(1);
            end

            if (lost && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign bus.pwr_o        = pwr_q;
    assign bus.pwr_valid_o  = pwr_vld_q;
    assign bus.trig_valid_o = trig_vld_q;
    assign bus.trig_pwr_o   = trig_pwr_q;
    assign bus.drop_cnt_o   = drop_q;
endmodule

// File: doc/beam_power_window_trigger.md
Name: beam_power_window_trigger

Overview:
- Sits directly downstream of the 8-way 5-bit ternary beamsum adder.
- Consumes its 8-bit offset-binary sum stream (nominal range 4..252, zero at 128) and converts each sample to signed.
- Squares each sample and accumulates the squares over a fixed power-of-2 window to produce beam power.
- Compares each window power against a runtime threshold and issues a holdoff-limited trigger through a valid/ready handshake.

Parameters:
- NSAMP_LOG2, 4, log2 of valid samples per window (window = 16).
- HOLDOFF, 8, number of completed windows suppressed after a trigger is issued.
- ACC_W, 15+NSAMP_LOG2, width of window power output. Derived; must not be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- dat_i  in  8  beamsum sample, offset binary (signed value = dat_i - 128)
- valid_i  in  1  dat_i is a valid sample this cycle
- thresh_i  in  ACC_W  unsigned power threshold; quasi-static
- pwr_o  out  ACC_W  last completed window power
- pwr_valid_o  out  1  one-cycle pulse when pwr_o updates
- trig_valid_o  out  1  trigger pending
- trig_ready_i  in  1  consumer accepts the trigger
- trig_pwr_o  out  ACC_W  window power that caused the pending trigger
- drop_cnt_o  out  8  saturating count of threshold crossings lost because a trigger was pending

Behaviour:
- Reset is synchronous and active-low on rst_ni; clock is clk_i. While rst_ni=0 at a clk_i edge:
  - all outputs go to 0;
  - window counter, accumulator, holdoff counter and pipeline valids are cleared.
  - A partial window in progress is discarded. The first valid sample after reset is sample 0 of a new window.
- Stage 1, cycle t+1 for a sample accepted at cycle t: s = dat_i - 128 (9-bit signed, -128..+127); register sq = s*s (15-bit unsigned, max 16384).
  - Out-of-nominal inputs (0..3, 253..255) are processed normally.
- Stage 2, cycle t+2:
  - Accumulator adds sq.
  - The window counter advances only on valid samples. Gaps in valid_i stretch the window but never corrupt it.
  - When the square of sample 2^NSAMP_LOG2-1 is added:
    - pwr_o = acc + sq;
    - pwr_valid_o = 1 for exactly one cycle;
    - the accumulator restarts from 0 for the next sample.
  - Latency: last sample at cycle t gives pwr_valid_o at t+2.
  - Back-to-back windows with valid_i held high lose no samples.
- Overflow is impossible: max power = 16384*2^NSAMP_LOG2 < 2^ACC_W. No saturation logic.
- Compare, cycle after pwr_valid_o: crossing = (pwr_o > thresh_i), strictly greater, using thresh_i sampled that cycle.
  - crossing and holdoff_cnt==0 and trig_valid_o==0: set trig_valid_o=1, latch trig_pwr_o=pwr_o, load holdoff_cnt=HOLDOFF.
  - crossing and holdoff_cnt==0 and trig_valid_o==1: drop_cnt_o increments, saturating at 255. Holdoff is not reloaded.
  - crossing and holdoff_cnt!=0: ignored silently; not counted as a drop.
- Holdoff: holdoff_cnt decrements by 1 at each compare cycle where it is nonzero. This is evaluated after the crossing decision of that compare cycle, so exactly HOLDOFF subsequent windows are suppressed.
  - HOLDOFF=0 means no suppression.
- Handshake: trig_valid_o and trig_pwr_o remain stable until a cycle with trig_valid_o & trig_ready_i, then trig_valid_o=0 on the next edge.
  - If a new trigger qualifies in the same cycle the old one is accepted, the new trigger wins: trig_valid_o stays 1, trig_pwr_o updates, and no drop is counted.
  - trig_ready_i is ignored while trig_valid_o=0.
- State: IDLE (no trigger pending) / PEND (trigger pending), with holdoff_cnt as an independent counter.

Test Plan:
- Reset, then 16 valid samples of dat_i=128 -> pwr_o=0, pwr_valid_o pulse 2 cycles after the 16th sample, no trigger.
- 16 samples dat_i=138 (s=10), thresh_i=1000 -> pwr_o=1600, trig_valid_o=1, trig_pwr_o=1600. Hold trig_ready_i=0 for 5 cycles -> trigger stays asserted and stable.
- 16 samples dat_i=0 (s=-128) -> pwr_o=262144 exactly, no wrap. Repeat with valid_i toggling every other cycle -> identical result, pulse 2 cycles after the 16th valid sample.
- HOLDOFF=2, thresh_i=0, continuous dat_i=130 (power 64/window), trig_ready_i=1 -> trigger on windows 0, 3, 6; drop_cnt_o=0.
- HOLDOFF=0, thresh_i=0, trig_ready_i=0, 300 windows of dat_i=130 -> one trigger with trig_pwr_o=64, drop_cnt_o saturates at 255.
- Assert rst_ni=0 for one cycle after 10 samples of dat_i=255, then 16 samples of dat_i=129 -> pwr_o=16 (partial window discarded), all outputs 0 during reset.
